fabric_seq_ctrl: RTL and testbench

//   Sequencer for the ternary fabric load path. Launches on a fabric_start rising edge from the
//   AXI register block and walks fabric_depth words from fabric_base_addr with fabric_stride.

---
 rtl/fabric_seq_ctrl_pkg.sv | 37 +++
 rtl/fabric_seq_ctrl_if.sv | 43 ++++
 rtl/fabric_seq_ctrl_credit_counter.sv | 58 +++++
 rtl/fabric_seq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_fabric_seq_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fabric_seq_ctrl_pkg.sv
// ============================================================================
// Module      : fabric_seq_ctrl_pkg
// Description : Shared definitions for the ternary fabric load sequencer.
//               Holds the sequencer state encoding, the widths of the job
//               configuration fields and small sizing helpers. The register
//               block and lane datapath use the same definitions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fabric_seq_ctrl_pkg;

  // Widths of the job configuration fields written by the register block.
  localparam int c_depth_width  = 16;
  localparam int c_stride_width = 8;

  // Sequencer states, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    FSEQ_IDLE  = 2'd0,
    FSEQ_ISSUE = 2'd1,
    FSEQ_DRAIN = 2'd2,
    FSEQ_DONE  = 2'd3
  } fseq_state_t;

  // Byte-address step of one word.
  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  // A credit counter must represent 0..max inclusive.
  function automatic int credit_width(input int max_outstanding);
    return $clog2(max_outstanding) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fabric_seq_ctrl_if.sv
// ============================================================================
// Module      : fabric_seq_ctrl_if
// Description : Fabric memory read bus between the sequencer (master) and
//               the fabric memory (slave).
//               mem_req_addr  : read request byte address
//               mem_req_valid : request valid, held with stable addr until ready
//               mem_req_ready : memory accepts request when valid & ready
//               mem_rsp_valid : in-order read response strobe, no backpressure
//               mem_rsp_data  : read response data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fabric_seq_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_data;

  modport master (
    output mem_req_addr,
    output mem_req_valid,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data
  );

  modport slave (
    input  mem_req_addr,
    input  mem_req_valid,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data
  );

endinterface

`default_nettype wire

// File: rtl/fabric_seq_ctrl_credit_counter.sv
// ============================================================================
// Module      : fabric_credit_counter
// Description : Outstanding-request credit counter. Counts up on an issued
//               request and down on a returned response; a simultaneous
//               up and down leaves the count unchanged. A down with the
//               count at zero and no same-cycle up is reported as underflow
//               and leaves the count at zero.
// Ports       : s_axi_aclk    in  clock
//               s_axi_aresetn in  asynchronous active-low reset
//               i_clear       in  synchronous clear (job launch)
//               i_inc         in  request handshake
//               i_dec         in  response strobe
//               o_full        out count == MAX_COUNT
//               o_empty       out count == 0
//               o_underflow   out i_dec with nothing outstanding
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fabric_credit_counter
  import fabric_seq_ctrl_pkg::*;
#(
  parameter int MAX_COUNT = 4,
  parameter int WIDTH     = credit_width(MAX_COUNT)
) (
  input  logic s_axi_aclk,
  input  logic s_axi_aresetn,
  input  logic i_clear,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_empty,
  output logic o_underflow
);

  localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] r_count;

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == c_max);
  assign o_underflow = i_dec & ~i_inc & o_empty;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc & ~i_dec & ~o_full) begin
      r_count <= r_count + 1'b1;
    end else if (i_dec & ~i_inc & ~o_empty) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fabric_seq_ctrl.sv
// ============================================================================
// Module      : fabric_seq_ctrl
// Description : Sequencer for the ternary fabric load path. A rising edge of
//               fabric_start in IDLE launches a job that reads fabric_depth
//               words starting at fabric_base_addr, stepping fabric_stride
//               words each time, with at most MAX_OUTSTANDING requests in
//               flight. Responses are forwarded in order to the lane
//               datapath, and a one-cycle fabric_done ends the job.
// Ports       : s_axi_aclk, s_axi_aresetn   clock, async active-low reset
//               fabric_base_addr/depth/stride job config, latched at launch
//               fabric_start                 level; rising edge launches
//               fabric_done                  one-cycle completion pulse
//               busy                         launch+1 through done pulse
//               mem (master)                 fabric memory read bus
//               lane_valid/data/last         registered response to lanes
//               rsp_err                      sticky unsolicited-response flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fabric_seq_ctrl
  import fabric_seq_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]     fabric_base_addr,
  input  logic [c_depth_width-1:0]  fabric_depth,
  input  logic [c_stride_width-1:0] fabric_stride,
  input  logic                      fabric_start,
  output logic                      fabric_done,
  output logic                      busy,
  fabric_seq_ctrl_if.master         mem,
  output logic                      lane_valid,
  output logic [DATA_WIDTH-1:0]     lane_data,
  output logic                      lane_last,
  output logic                      rsp_err
);

  localparam int c_bytes_per_word = bytes_per_word(DATA_WIDTH);

  fseq_state_t                r_state;
  logic                       r_start_q;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic [c_depth_width-1:0]   r_depth;
  logic [c_stride_width-1:0]  r_stride;
  logic [c_depth_width-1:0]   r_issued;
  logic [c_depth_width-1:0]   r_received;
  logic                       r_done;
  logic                       r_busy;
  logic                       r_rsp_err;
  logic                       r_lane_valid;
  logic [DATA_WIDTH-1:0]      r_lane_data;
  logic                       r_lane_last;

  logic                       w_launch;
  logic                       w_req_valid;
  logic                       w_req_fire;
  logic                       w_rsp_live;
  logic                       w_rsp_accept;
  logic                       w_credit_full;
  logic                       w_credit_empty;
  logic                       w_underflow;
  logic [ADDR_WIDTH-1:0]      w_step;
  logic [c_depth_width-1:0]   w_issued_next;
  logic [c_depth_width-1:0]   w_received_next;

  // Edge detect only in IDLE, so a start left high across a job (or raised
  // mid-job) cannot relaunch until it drops and rises again.
  assign w_launch = (r_state == FSEQ_IDLE) & fabric_start & ~r_start_q;

  // Valid is a function of registered state only: it can only fall through
  // a handshake, which keeps valid/addr stable while ready is low.
  assign w_req_valid = (r_state == FSEQ_ISSUE) & (r_issued < r_depth) & ~w_credit_full;
  assign w_req_fire  = w_req_valid & mem.mem_req_ready;

  // Responses in IDLE belong to no job (e.g. in flight across a reset).
  assign w_rsp_live   = mem.mem_rsp_valid & (r_state != FSEQ_IDLE);
  assign w_rsp_accept = w_rsp_live & ~w_underflow;

  // Address arithmetic wraps naturally modulo 2^ADDR_WIDTH.
  assign w_step          = ADDR_WIDTH'(r_stride) * ADDR_WIDTH'(c_bytes_per_word);
  assign w_issued_next   = r_issued + 1'b1;
  assign w_received_next = r_received + 1'b1;

  assign mem.mem_req_addr  = r_addr;
  assign mem.mem_req_valid = w_req_valid;

  assign fabric_done = r_done;
  assign busy        = r_busy;
  assign rsp_err     = r_rsp_err;
  assign lane_valid  = r_lane_valid;
  assign lane_data   = r_lane_data;
  assign lane_last   = r_lane_last;

  fabric_credit_counter #(
    .MAX_COUNT (MAX_OUTSTANDING)
  ) u_credit (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .i_clear       (w_launch),
    .i_inc         (w_req_fire),
    .i_dec         (w_rsp_live),
    .o_full        (w_credit_full),
    .o_empty       (w_credit_empty),
    .o_underflow   (w_underflow)
  );

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state      <= FSEQ_IDLE;
      r_start_q    <= 1'b0;
      r_addr       <= '0;
      r_depth      <= '0;
      r_stride     <= '0;
      r_issued     <= '0;
      r_received   <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_lane_valid <= 1'b0;
      r_lane_data  <= '0;
      r_lane_last  <= 1'b0;
    end else begin
      r_start_q    <= fabric_start;
      r_done       <= 1'b0;
      r_lane_valid <= w_rsp_accept;
      r_lane_last  <= w_rsp_accept & (w_received_next == r_depth);

      if (w_rsp_accept) begin
        r_lane_data <= mem.mem_rsp_data;
        r_received  <= w_received_next;
      end

      if (w_rsp_live & w_underflow) begin
        r_rsp_err <= 1'b1;
      end

      case (r_state)
        FSEQ_IDLE: begin
          if (w_launch) begin
            r_addr     <= fabric_base_addr;
            r_depth    <= fabric_depth;
            r_stride   <= fabric_stride;
            r_issued   <= '0;
            r_received <= '0;
            r_rsp_err  <= 1'b0;
            r_busy     <= 1'b1;
            // An empty job goes straight to DONE so done pulses in the
            // first cycle after launch.
            if (fabric_depth == '0) begin
              r_state <= FSEQ_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= FSEQ_ISSUE;
            end
          end
        end

        FSEQ_ISSUE: begin
          if (w_req_fire) begin
            r_addr   <= r_addr + w_step;
            r_issued <= w_issued_next;
            if (w_issued_next == r_depth) begin
              r_state <= FSEQ_DRAIN;
            end
          end
        end

        FSEQ_DRAIN: begin
          if (w_credit_empty && (r_received == r_depth)) begin
            r_state <= FSEQ_DONE;
            r_done  <= 1'b1;
          end
        end

        FSEQ_DONE: begin
          r_state <= FSEQ_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= FSEQ_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fabric_seq_ctrl.sv
// ============================================================================
// Module      : tb_fabric_seq_ctrl
// Description : Self-checking bench for fabric_seq_ctrl. A behavioural memory
//               answers requests in order after a random latency; expected
//               addresses come from base + i*stride*4 and expected lane data
//               from the responses the memory model returned.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fabric_seq_ctrl;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  logic          s_axi_aclk = 1'b0;
  logic          s_axi_aresetn;
  logic [31:0]   fabric_base_addr;
  logic [15:0]   fabric_depth;
  logic [7:0]    fabric_stride;
  logic          fabric_start;
  logic          fabric_done;
  logic          busy;
  logic          lane_valid;
  logic [31:0]   lane_data;
  logic          lane_last;
  logic          rsp_err;

  fabric_seq_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fabric_seq_ctrl #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .s_axi_aclk       (s_axi_aclk),
    .s_axi_aresetn    (s_axi_aresetn),
    .fabric_base_addr (fabric_base_addr),
    .fabric_depth     (fabric_depth),
    .fabric_stride    (fabric_stride),
    .fabric_start     (fabric_start),
    .fabric_done      (fabric_done),
    .busy             (busy),
    .mem              (bus),
    .lane_valid       (lane_valid),
    .lane_data        (lane_data),
    .lane_last        (lane_last),
    .rsp_err          (rsp_err)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Memory model controls
  int ready_mode   = 0;   // 0: always ready, 1: random, 2: never
  int lat_min      = 1;
  int lat_max      = 1;
  bit rsp_hold     = 1'b0;
  bit inject_extra = 1'b0;
  int inject_at    = -1;

  // Job bookkeeping
  int job_depth       = 0;
  int rsp_cnt         = 0;
  int last_due        = 0;
  int launch_cyc      = 0;
  int first_valid_cyc = -1;
  int done_cnt        = 0;
  int done_cyc        = -1;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  rsp_t        pend_q[$];
  logic [31:0] req_addr_q[$];
  logic [31:0] exp_data_q[$];
  int          rsp_cyc_q[$];
  logic [31:0] lane_data_q[$];
  bit          lane_last_q[$];
  int          lane_cyc_q[$];

  function automatic logic [31:0] exp_addr(input logic [31:0] base, input logic [7:0] stride, input int i);
    return base + 32'(i) * 32'(stride) * 32'd4;
  endfunction

  // One clock cycle: drive memory inputs, observe the DUT, advance.
  task automatic tick();
    rsp_t r;
    case (ready_mode)
      0:       bus.mem_req_ready = 1'b1;
      1:       bus.mem_req_ready = 1'($urandom_range(0, 1));
      default: bus.mem_req_ready = 1'b0;
    endcase
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    if (!rsp_hold && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      r = pend_q.pop_front();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = r.data;
      exp_data_q.push_back(r.data);
      rsp_cyc_q.push_back(cyc);
      rsp_cnt++;
      if (inject_extra && rsp_cnt == job_depth) inject_at = cyc + 1;
    end else if (cyc == inject_at) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      req_addr_q.push_back(bus.mem_req_addr);
      r.due = cyc + int'($urandom_range(lat_min, lat_max));
      if (r.due <= last_due) r.due = last_due + 1;
      last_due = r.due;
      r.data = $urandom;
      pend_q.push_back(r);
    end
    if (bus.mem_req_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (lane_valid) begin
      lane_data_q.push_back(lane_data);
      lane_last_q.push_back(lane_last);
      lane_cyc_q.push_back(cyc);
    end
    if (fabric_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge s_axi_aclk);
    #1;
    cyc++;
  endtask

  // Drops start for a cycle, then raises it with the given config. Returns
  // in the cycle after launch; config inputs are then scrambled.
  task automatic start_job(input logic [31:0] base, input logic [15:0] depth, input logic [7:0] stride);
    fabric_start = 1'b0;
    tick();
    pend_q.delete(); req_addr_q.delete(); exp_data_q.delete(); rsp_cyc_q.delete();
    lane_data_q.delete(); lane_last_q.delete(); lane_cyc_q.delete();
    rsp_cnt = 0; last_due = cyc; inject_at = -1; first_valid_cyc = -1;
    done_cnt = 0; done_cyc = -1; job_depth = int'(depth);
    fabric_base_addr = base; fabric_depth = depth; fabric_stride = stride;
    fabric_start = 1'b1;
    launch_cyc = cyc;
    tick();
    fabric_base_addr = $urandom;
    fabric_depth     = 16'($urandom);
    fabric_stride    = 8'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    ok = (done_cnt > 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    s_axi_aresetn = 1'b0;
    repeat (3) @(posedge s_axi_aclk);
    #1;
    total++; if (bus.mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.mem_req_valid); end
    total++; if (bus.mem_req_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", bus.mem_req_addr); end
    total++; if ({fabric_done, busy, lane_valid, lane_last, rsp_err} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000", {fabric_done, busy, lane_valid, lane_last, rsp_err}); end
    total++; if (lane_data !== 32'h0) begin bad++; $display("FAIL reset_lane_data: got %h want 0", lane_data); end
    s_axi_aresetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    ready_mode = 0; lat_min = 1; lat_max = 1;
    start_job(32'h1000, 16'd4, 8'd1);
    fabric_start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_at_launch1: got %b want 1", busy); end
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout: done not seen"); end
    total++; if (req_addr_q.size() != 4) begin bad++; $display("FAIL basic_req_count: got %0d want 4", req_addr_q.size()); end
    for (int i = 0; i < 4 && i < req_addr_q.size(); i++) begin
      total++; if (req_addr_q[i] !== exp_addr(32'h1000, 8'd1, i)) begin
        bad++; $display("FAIL basic_addr[%0d]: got %h want %h", i, req_addr_q[i], exp_addr(32'h1000, 8'd1, i)); end
    end
    total++; if (lane_data_q.size() != 4) begin bad++; $display("FAIL basic_lane_count: got %0d want 4", lane_data_q.size()); end
    for (int i = 0; i < 4 && i < lane_data_q.size() && i < exp_data_q.size(); i++) begin
      total++; if (lane_data_q[i] !== exp_data_q[i] || lane_last_q[i] !== (i == 3)) begin
        bad++; $display("FAIL basic_lane[%0d]: got %h/%b want %h/%b", i, lane_data_q[i], lane_last_q[i], exp_data_q[i], (i == 3)); end
    end
    total++; if (first_valid_cyc != launch_cyc + 1) begin bad++; $display("FAIL basic_first_valid: got %0d want %0d", first_valid_cyc, launch_cyc + 1); end
    if (rsp_cyc_q.size() == 4 && lane_cyc_q.size() == 4) begin
      total++; if (lane_cyc_q[3] != rsp_cyc_q[3] + 1) begin bad++; $display("FAIL basic_last_latency: got %0d want %0d", lane_cyc_q[3], rsp_cyc_q[3] + 1); end
      total++; if (done_cyc != rsp_cyc_q[3] + 2) begin bad++; $display("FAIL basic_done_latency: got %0d want %0d", done_cyc, rsp_cyc_q[3] + 2); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    total++; if (busy !== 1'b0 || rsp_err !== 1'b0) begin bad++; $display("FAIL basic_end_flags: got busy=%b err=%b want 0 0", busy, rsp_err); end
  endtask

  task automatic test_credits();
    bit ok;
    ready_mode = 0; lat_min = 1; lat_max = 1; rsp_hold = 1'b1;
    start_job(32'h0, 16'd8, 8'd2);
    fabric_start = 1'b0;
    repeat (10) tick();
    total++; if (req_addr_q.size() != MAXO) begin bad++; $display("FAIL credit_held_count: got %0d want %0d", req_addr_q.size(), MAXO); end
    total++; if (bus.mem_req_valid !== 1'b0) begin bad++; $display("FAIL credit_valid_low: got %b want 0", bus.mem_req_valid); end
    rsp_hold = 1'b0;
    tick();
    rsp_hold = 1'b1;
    repeat (3) tick();
    total++; if (req_addr_q.size() != MAXO + 1) begin bad++; $display("FAIL credit_one_freed: got %0d want %0d", req_addr_q.size(), MAXO + 1); end
    rsp_hold = 1'b0;
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL credit_timeout: done not seen"); end
    total++; if (req_addr_q.size() != 8) begin bad++; $display("FAIL credit_req_count: got %0d want 8", req_addr_q.size()); end
    for (int i = 0; i < 8 && i < req_addr_q.size(); i++) begin
      total++; if (req_addr_q[i] !== 32'(i * 8)) begin bad++; $display("FAIL credit_addr[%0d]: got %h want %h", i, req_addr_q[i], 32'(i * 8)); end
    end
    total++; if (lane_data_q.size() != 8) begin bad++; $display("FAIL credit_lane_count: got %0d want 8", lane_data_q.size()); end
    for (int i = 0; i < 8 && i < lane_data_q.size() && i < exp_data_q.size(); i++) begin
      total++; if (lane_data_q[i] !== exp_data_q[i] || lane_last_q[i] !== (i == 7)) begin
        bad++; $display("FAIL credit_lane[%0d]: got %h/%b want %h/%b", i, lane_data_q[i], lane_last_q[i], exp_data_q[i], (i == 7)); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL credit_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_zero_depth();
    ready_mode = 0;
    start_job(32'h40, 16'd0, 8'd5);
    total++; if (fabric_done !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL zero_done_now: got done=%b busy=%b want 1 1", fabric_done, busy); end
    repeat (10) tick();
    total++; if (done_cnt != 1 || done_cyc != launch_cyc + 1) begin
      bad++; $display("FAIL zero_done_once: got cnt=%0d cyc=%0d want 1 %0d", done_cnt, done_cyc, launch_cyc + 1); end
    total++; if (first_valid_cyc != -1 || req_addr_q.size() != 0) begin
      bad++; $display("FAIL zero_no_request: got first_valid=%0d reqs=%0d want -1 0", first_valid_cyc, req_addr_q.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_no_relaunch: got busy=%b want 0", busy); end
    fabric_start = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
    ready_mode = 0; lat_min = 1; lat_max = 2;
    start_job(32'hFFFF_FFF8, 16'd3, 8'd1);
    fabric_start = 1'b0;
    wait_done(100, ok);
    total++; if (!ok || req_addr_q.size() != 3) begin bad++; $display("FAIL wrap_count: got ok=%b reqs=%0d want 1 3", ok, req_addr_q.size()); end
    for (int i = 0; i < 3 && i < req_addr_q.size(); i++) begin
      total++; if (req_addr_q[i] !== want[i]) begin bad++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, req_addr_q[i], want[i]); end
    end
    total++; if (lane_data_q.size() != 3) begin bad++; $display("FAIL wrap_lane_count: got %0d want 3", lane_data_q.size()); end
  endtask

  task automatic test_stall_err();
    bit ok;
    ready_mode = 2; lat_min = 1; lat_max = 1;
    start_job(32'h2000, 16'd3, 8'd1);
    fabric_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h2000) begin
        bad++; $display("FAIL stall_hold[%0d]: got valid=%b addr=%h want 1 00002000", i, bus.mem_req_valid, bus.mem_req_addr); end
      tick();
    end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL stall_err_cleared: got %b want 0", rsp_err); end
    ready_mode = 0; inject_extra = 1'b1;
    wait_done(100, ok);
    inject_extra = 1'b0;
    total++; if (!ok || req_addr_q.size() != 3) begin bad++; $display("FAIL stall_finish: got ok=%b reqs=%0d want 1 3", ok, req_addr_q.size()); end
    total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL stall_rsp_err: got %b want 1", rsp_err); end
    total++; if (lane_data_q.size() != 3) begin bad++; $display("FAIL stall_lane_count: got %0d want 3", lane_data_q.size()); end
    for (int i = 0; i < 3 && i < lane_data_q.size() && i < exp_data_q.size(); i++) begin
      total++; if (lane_data_q[i] !== exp_data_q[i]) begin bad++; $display("FAIL stall_lane[%0d]: got %h want %h", i, lane_data_q[i], exp_data_q[i]); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL stall_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    ready_mode = 0; lat_min = 1; lat_max = 1; rsp_hold = 1'b1;
    start_job(32'h3000, 16'd8, 8'd1);
    fabric_start = 1'b0;
    while (req_addr_q.size() < 2 && n < 20) begin tick(); n++; end
    total++; if (req_addr_q.size() != 2) begin bad++; $display("FAIL rmid_outstanding: got %0d want 2", req_addr_q.size()); end
    s_axi_aresetn = 1'b0;
    #1;
    total++; if ({bus.mem_req_valid, busy, fabric_done, lane_valid} !== 4'b0) begin
      bad++; $display("FAIL rmid_outputs: got %b want 0000", {bus.mem_req_valid, busy, fabric_done, lane_valid}); end
    repeat (3) tick();
    s_axi_aresetn = 1'b1;
    pend_q.delete();
    rsp_hold = 1'b0;
    inject_at = cyc;
    repeat (3) tick();
    total++; if (done_cnt != 0) begin bad++; $display("FAIL rmid_no_done: got %0d want 0", done_cnt); end
    total++; if (lane_data_q.size() != 0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL rmid_late_rsp: got lanes=%0d err=%b want 0 0", lane_data_q.size(), rsp_err); end
    lat_max = 3;
    start_job(32'h5000, 16'd5, 8'd3);
    fabric_start = 1'b0;
    wait_done(200, ok);
    total++; if (!ok || req_addr_q.size() != 5 || done_cnt != 1) begin
      bad++; $display("FAIL rmid_clean_job: got ok=%b reqs=%0d done=%0d want 1 5 1", ok, req_addr_q.size(), done_cnt); end
    for (int i = 0; i < 5 && i < req_addr_q.size(); i++) begin
      total++; if (req_addr_q[i] !== exp_addr(32'h5000, 8'd3, i)) begin
        bad++; $display("FAIL rmid_addr[%0d]: got %h want %h", i, req_addr_q[i], exp_addr(32'h5000, 8'd3, i)); end
    end
    total++; if (lane_data_q.size() != 5 || exp_data_q.size() != 5 || lane_data_q != exp_data_q) begin
      bad++; $display("FAIL rmid_lanes: got %0d words want 5 matching", lane_data_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    ready_mode = 1; lat_min = 1; lat_max = 3;
    start_job(32'h100, 16'd6, 8'd2);
    fabric_start = 1'b0;
    tick(); tick();
    fabric_start = 1'b1;
    tick();
    fabric_start = 1'b0;
    wait_done(300, ok);
    repeat (5) tick();
    total++; if (!ok || done_cnt != 1) begin bad++; $display("FAIL b2b_first_done: got ok=%b done=%0d want 1 1", ok, done_cnt); end
    total++; if (req_addr_q.size() != 6 || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_no_relaunch: got reqs=%0d busy=%b want 6 0", req_addr_q.size(), busy); end
    start_job(32'h200, 16'd2, 8'd1);
    fabric_start = 1'b0;
    wait_done(100, ok);
    total++; if (!ok || req_addr_q.size() != 2 || done_cnt != 1) begin
      bad++; $display("FAIL b2b_second: got ok=%b reqs=%0d done=%0d want 1 2 1", ok, req_addr_q.size(), done_cnt); end
    for (int i = 0; i < 2 && i < req_addr_q.size(); i++) begin
      total++; if (req_addr_q[i] !== exp_addr(32'h200, 8'd1, i)) begin
        bad++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, req_addr_q[i], exp_addr(32'h200, 8'd1, i)); end
    end
  endtask

  task automatic test_random();
    bit          ok;
    logic [31:0] base;
    logic [15:0] depth;
    logic [7:0]  stride;
    for (int j = 0; j < 6; j++) begin
      ready_mode = 1; lat_min = 1; lat_max = int'($urandom_range(1, 4));
      base   = $urandom;
      depth  = 16'($urandom_range(1, 20));
      stride = (j == 0) ? 8'd0 : 8'($urandom);
      start_job(base, depth, stride);
      fabric_start = 1'b0;
      wait_done(600, ok);
      total++; if (!ok || req_addr_q.size() != int'(depth)) begin
        bad++; $display("FAIL rand%0d_count: got ok=%b reqs=%0d want 1 %0d", j, ok, req_addr_q.size(), depth); end
      for (int i = 0; i < int'(depth) && i < req_addr_q.size(); i++) begin
        total++; if (req_addr_q[i] !== exp_addr(base, stride, i)) begin
          bad++; $display("FAIL rand%0d_addr[%0d]: got %h want %h", j, i, req_addr_q[i], exp_addr(base, stride, i)); end
      end
      total++; if (lane_data_q.size() != int'(depth)) begin
        bad++; $display("FAIL rand%0d_lane_count: got %0d want %0d", j, lane_data_q.size(), depth); end
      for (int i = 0; i < lane_data_q.size() && i < exp_data_q.size(); i++) begin
        total++; if (lane_data_q[i] !== exp_data_q[i] || lane_last_q[i] !== (i == int'(depth) - 1)) begin
          bad++; $display("FAIL rand%0d_lane[%0d]: got %h/%b want %h/%b", j, i, lane_data_q[i], lane_last_q[i], exp_data_q[i], (i == int'(depth) - 1)); end
      end
      total++; if (done_cnt != 1 || rsp_err !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL rand%0d_end: got done=%0d err=%b busy=%b want 1 0 0", j, done_cnt, rsp_err, busy); end
    end
  endtask

  initial begin
    s_axi_aresetn     = 1'b0;
    fabric_base_addr  = '0;
    fabric_depth      = '0;
    fabric_stride     = '0;
    fabric_start      = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    test_reset();
    test_basic();
    test_credits();
    test_zero_depth();
    test_wrap();
    test_stall_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
